hdmi_frame_fetch: RTL and testbench

Frame-buffer fetch stage sitting directly upstream of the HDMI timing core. Turns the core's read_go / read_next_line / read_next_chunk / read_done requests into burst reads from a memory master port. Buffers returned pixel words in an internal FIFO that the core drains with read_fifo, one 32-bit word per pixel.

---
 rtl/hdmi_frame_fetch.sv | 191 +++++++++++++++++++
 tb/tb_hdmi_frame_fetch.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_frame_fetch.sv
// rtl/hdmi_frame_fetch.sv - frame-buffer burst fetch stage feeding the HDMI timing core
//
// Purpose: turns the timing core's read_go / read_next_line / read_next_chunk /
// read_done requests into CHUNK-word burst reads on a memory master port and
// buffers the returned pixel words in a first-word-fall-through FIFO.
//
// Ports:
//   clock, resetn                 clock, asynchronous active-low reset
//   frame_base, line_stride       frame origin and line pitch, sampled on read_go
//   read_go, read_next_line,
//   read_next_chunk, read_done    one-cycle request pulses from the timing core
//   read_fifo, fifo_dout,
//   fifo_empty                    FIFO pop, head word, empty flag
//   mem_req, mem_addr, mem_len,
//   mem_ack                       burst request handshake
//   mem_rvalid, mem_rdata         returned burst data, in address order
//   busy                          state is not IDLE
//   underflow_cnt                 pops seen on an empty FIFO (HDMI_FETCH_UNDERFLOW_EN only)
//
// Build option: define HDMI_FETCH_UNDERFLOW_EN to add the underflow_cnt output.
module hdmi_frame_fetch #(
  parameter int CHUNK      = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int AW         = 32
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [AW-1:0] frame_base,
  input  logic [15:0]   line_stride,
  input  logic          read_go,
  input  logic          read_next_line,
  input  logic          read_next_chunk,
  input  logic          read_done,
  input  logic          read_fifo,
  output logic [31:0]   fifo_dout,
  output logic          fifo_empty,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [6:0]    mem_len,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          busy
`ifdef HDMI_FETCH_UNDERFLOW_EN
  ,
  output logic [15:0]   underflow_cnt
`endif
);

  localparam int BW = $clog2(CHUNK);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] CHUNK_BYTES = AW'(CHUNK * 4);

  typedef enum logic [1:0] {IDLE, ARMED, REQ, DATA} state_t;
  state_t state, state_n;

  logic [AW-1:0] line_addr, chunk_addr;
  logic [15:0]   stride;
  logic [2:0]    pending;
  logic          line_flag;
  logic          draining;   // beats of an aborted burst still arriving
  logic          go_held;    // read_go seen while draining
  logic [BW-1:0] beat_cnt;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free_space;

  logic in_burst, beat_last, need_drain, flush;
  logic arm_line, issue, fifo_wr, fifo_pop, pend_inc;

  assign free_space = CW'(FIFO_DEPTH) - count;

  always_comb begin
    in_burst   = (state == DATA) || draining;
    beat_last  = in_burst && mem_rvalid && (beat_cnt == BW'(CHUNK - 1));
    need_drain = in_burst && !beat_last;
    flush      = read_go || read_done;
    // A pending line change is applied before any further burst is issued.
    arm_line   = (state == ARMED) && line_flag && !flush;
    issue      = (state == ARMED) && !line_flag && (pending != 3'd0) &&
                 (free_space >= CW'(CHUNK)) && !flush;
    fifo_wr    = (state == DATA) && mem_rvalid && !flush;
    fifo_pop   = read_fifo && (count != '0) && !flush;
    pend_inc   = read_next_chunk && (state != IDLE) && (pending != 3'd7);

    state_n = state;
    if (read_go) begin
      // Restart at once unless an acked burst still owes beats; then hold.
      state_n = need_drain ? IDLE : ARMED;
    end else if (read_done) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (beat_last && go_held) state_n = ARMED;
        ARMED:   if (issue) state_n = REQ;
        REQ:     if (mem_ack) state_n = DATA;
        DATA:    if (beat_last) state_n = ARMED;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      line_addr  <= '0;
      chunk_addr <= '0;
      stride     <= '0;
      pending    <= '0;
      line_flag  <= 1'b0;
      draining   <= 1'b0;
      go_held    <= 1'b0;
      beat_cnt   <= '0;
      mem_addr   <= '0;
    end else begin
      if (in_burst && mem_rvalid) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;

      if (flush)          draining <= need_drain;
      else if (beat_last) draining <= 1'b0;

      if (read_go)                    go_held <= need_drain;
      else if (read_done || beat_last) go_held <= 1'b0;

      if (flush) pending <= '0;
      else       pending <= pending + {2'b0, pend_inc} - {2'b0, issue};

      if (flush)                                  line_flag <= 1'b0;
      else if (read_next_line && state != IDLE)   line_flag <= 1'b1;
      else if (arm_line)                          line_flag <= 1'b0;

      if (read_go) begin
        line_addr  <= frame_base;
        chunk_addr <= frame_base;
        stride     <= line_stride;
      end else if (arm_line) begin
        line_addr  <= line_addr + AW'(stride);
        chunk_addr <= line_addr + AW'(stride);
      end else if (state == REQ && mem_ack && !read_done) begin
        chunk_addr <= chunk_addr + CHUNK_BYTES;
      end

      if (issue) mem_addr <= chunk_addr;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(fifo_wr) - CW'(fifo_pop);
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge clock) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= mem_rdata;
  end

`ifdef HDMI_FETCH_UNDERFLOW_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      underflow_cnt <= '0;
    else if (read_go)
      underflow_cnt <= '0;
    else if (read_fifo && count == '0 && state != IDLE && underflow_cnt != 16'hFFFF)
      underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

  assign fifo_empty = (count == '0);
  assign fifo_dout  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr];
  assign mem_req    = (state == REQ);
  assign mem_len    = 7'(CHUNK);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_hdmi_frame_fetch.sv
// tb/tb_hdmi_frame_fetch.sv - self-checking bench for hdmi_frame_fetch
`timescale 1ns/1ps
module tb_hdmi_frame_fetch;
  localparam int CHUNK = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 32;
  localparam int P_GO = 0, P_CHUNK = 1, P_LINE = 2, P_DONE = 3, P_BOTH = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic [15:0]   line_stride = '0;
  logic          read_go = 0, read_next_line = 0, read_next_chunk = 0, read_done = 0;
  logic          read_fifo = 0;
  logic [31:0]   fifo_dout;
  logic          fifo_empty;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [6:0]    mem_len;
  logic          mem_ack = 0, mem_rvalid = 0;
  logic [31:0]   mem_rdata = '0;
  logic          busy;
`ifdef HDMI_FETCH_UNDERFLOW_EN
  logic [15:0]   underflow_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int requested, acked;

  hdmi_frame_fetch #(.CHUNK(CHUNK), .FIFO_DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .resetn(resetn), .frame_base(frame_base), .line_stride(line_stride),
    .read_go(read_go), .read_next_line(read_next_line), .read_next_chunk(read_next_chunk),
    .read_done(read_done), .read_fifo(read_fifo), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
`ifdef HDMI_FETCH_UNDERFLOW_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse(input int which);
    case (which)
      P_GO:    read_go = 1;
      P_CHUNK: read_next_chunk = 1;
      P_LINE:  read_next_line = 1;
      P_DONE:  read_done = 1;
      default: begin read_next_chunk = 1; read_next_line = 1; end
    endcase
    @(negedge clock);
    read_go = 0; read_next_chunk = 0; read_next_line = 0; read_done = 0;
  endtask

  task automatic wait_req(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (mem_req) begin ok = 1; break; end
      @(negedge clock);
    end
  endtask

  task automatic serve(input logic [31:0] first);
    mem_ack = 1;
    @(negedge clock);
    mem_ack = 0;
    for (int i = 0; i < CHUNK; i++) begin
      mem_rvalid = 1; mem_rdata = first + 32'(i);
      @(negedge clock);
    end
    mem_rvalid = 0;
  endtask

  task automatic beats(input int n, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1; mem_rdata = first + 32'(i);
      @(negedge clock);
    end
    mem_rvalid = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    cyc(3);
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_fifo_empty got %b want 1", fifo_empty); end
    tests++; if (fifo_dout !== 32'd0) begin fails++; $display("FAIL reset_fifo_dout got %h want 0", fifo_dout); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    tests++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    tests++; if (mem_len !== 7'd16) begin fails++; $display("FAIL reset_mem_len got %0d want 16", mem_len); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    resetn = 1;
    cyc(1);
  endtask

`ifdef HDMI_FETCH_UNDERFLOW_EN
  task automatic test_underflow();
    frame_base = 32'h100; pulse(P_GO);
    read_fifo = 1; cyc(3); read_fifo = 0; cyc(1);
    tests++; if (underflow_cnt !== 16'd3) begin fails++; $display("FAIL underflow_count got %0d want 3", underflow_cnt); end
    pulse(P_GO);
    tests++; if (underflow_cnt !== 16'd0) begin fails++; $display("FAIL underflow_clear got %0d want 0", underflow_cnt); end
    pulse(P_DONE);
  endtask
`endif

  task automatic test_basic_burst();
    frame_base = 32'h1000; line_stride = 16'd5120;
    pulse(P_GO);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL go_busy got %b want 1", busy); end
    pulse(P_CHUNK);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL req_early got %b want 0", mem_req); end
    cyc(1);
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL req_latency got %b want 1", mem_req); end
    tests++; if (mem_addr !== 32'h1000) begin fails++; $display("FAIL basic_addr got %h want 00001000", mem_addr); end
    tests++; if (mem_len !== 7'd16) begin fails++; $display("FAIL basic_len got %0d want 16", mem_len); end
    mem_ack = 1; cyc(1); mem_ack = 0;
    for (int i = 0; i < CHUNK; i++) begin
      mem_rvalid = 1; mem_rdata = 32'(i);
      @(negedge clock);
      if (i == 0) begin
        tests++;
        if (fifo_empty !== 1'b0 || fifo_dout !== 32'd0) begin
          fails++; $display("FAIL data_latency got empty=%b dout=%h want empty=0 dout=0", fifo_empty, fifo_dout);
        end
      end
    end
    mem_rvalid = 0;
    for (int i = 0; i < CHUNK; i++) begin
      tests++; if (fifo_dout !== 32'(i)) begin fails++; $display("FAIL basic_pop%0d got %h want %h", i, fifo_dout, i); end
      read_fifo = 1; @(negedge clock);
    end
    read_fifo = 0;
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL basic_drained got %b want 1", fifo_empty); end
  endtask

  task automatic test_line_advance();
    bit ok;
    frame_base = 32'h1000; line_stride = 16'd5120;
    pulse(P_GO);
    pulse(P_CHUNK); wait_req(10, ok);
    tests++; if (!ok || mem_addr !== 32'h1000) begin fails++; $display("FAIL line_a0 got %h req=%b want 00001000", mem_addr, ok); end
    serve(32'h100);
    pulse(P_CHUNK); wait_req(10, ok);
    tests++; if (!ok || mem_addr !== 32'h1040) begin fails++; $display("FAIL line_a1 got %h req=%b want 00001040", mem_addr, ok); end
    serve(32'h200);
    pulse(P_BOTH);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL line_wait1 got %b want 0", mem_req); end
    cyc(1);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL line_wait2 got %b want 0", mem_req); end
    cyc(1);
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h2400) begin fails++; $display("FAIL line_a2 got %h req=%b want 00002400", mem_addr, mem_req); end
    serve(32'h300);
    pulse(P_DONE);
  endtask

  task automatic test_back_pressure();
    bit ok;
    int served;
    frame_base = 32'h1000;
    pulse(P_GO);
    for (int i = 0; i < 5; i++) pulse(P_CHUNK);
    served = 0;
    for (int b = 0; b < 5; b++) begin
      wait_req(20, ok);
      if (!ok) break;
      serve(32'(b * 100));
      served++;
    end
    tests++; if (served !== 4) begin fails++; $display("FAIL bp_bursts got %0d want 4", served); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL bp_full_req got %b want 0", mem_req); end
    for (int i = 0; i < 15; i++) begin
      tests++; if (fifo_dout !== 32'(i)) begin fails++; $display("FAIL bp_pop%0d got %h want %h", i, fifo_dout, i); end
      read_fifo = 1; @(negedge clock);
    end
    read_fifo = 0;
    cyc(4);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL bp_15pops_req got %b want 0", mem_req); end
    read_fifo = 1; @(negedge clock); read_fifo = 0;
    wait_req(5, ok);
    tests++; if (!ok || mem_addr !== 32'h1100) begin fails++; $display("FAIL bp_fifth got %h req=%b want 00001100", mem_addr, ok); end
    pulse(P_DONE);
  endtask

  task automatic test_abort();
    bit ok;
    frame_base = 32'h8000;
    pulse(P_GO); pulse(P_CHUNK); wait_req(10, ok);
    mem_ack = 1; cyc(1); mem_ack = 0;
    beats(5, 32'hA0);
    pulse(P_DONE);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    beats(11, 32'hB0);
    tests++; if (fifo_empty !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL abort_discard got empty=%b busy=%b want 1 0", fifo_empty, busy); end
    frame_base = 32'hA000;
    pulse(P_GO); pulse(P_CHUNK); wait_req(10, ok);
    tests++; if (!ok || mem_addr !== 32'hA000) begin fails++; $display("FAIL abort_restart got %h req=%b want 0000a000", mem_addr, ok); end
    mem_ack = 1; cyc(1); mem_ack = 0;
    beats(3, 32'hC0);
    frame_base = 32'hC000;
    pulse(P_GO);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL held_go_drain got busy=%b want 0", busy); end
    beats(13, 32'hD0);
    tests++; if (busy !== 1'b1 || fifo_empty !== 1'b1) begin fails++; $display("FAIL held_go_resume got busy=%b empty=%b want 1 1", busy, fifo_empty); end
    pulse(P_CHUNK); wait_req(10, ok);
    tests++; if (!ok || mem_addr !== 32'hC000) begin fails++; $display("FAIL held_go_addr got %h req=%b want 0000c000", mem_addr, ok); end
    pulse(P_DONE);
  endtask

  task automatic test_async_reset();
    bit ok;
    frame_base = 32'h4440;
    pulse(P_GO); pulse(P_CHUNK); wait_req(10, ok);
    mem_ack = 1; cyc(1); mem_ack = 0;
    beats(3, 32'h77);
    #2 resetn = 0;
    #1;
    tests++;
    if (busy !== 1'b0 || fifo_empty !== 1'b1 || fifo_dout !== 32'd0 || mem_addr !== 32'd0 || mem_req !== 1'b0) begin
      fails++; $display("FAIL async_reset got busy=%b empty=%b dout=%h addr=%h req=%b want 0 1 0 0 0",
                        busy, fifo_empty, fifo_dout, mem_addr, mem_req);
    end
    @(negedge clock); resetn = 1; cyc(1);
  endtask

  task automatic test_random();
    int nlines, total;
    int nchunks[3];
    logic [31:0] base;
    logic [15:0] stride;
    for (int f = 0; f < 4; f++) begin
      base   = $urandom & 32'hFFFF_FFFC;
      stride = 16'($urandom_range(1, 16383) * 4);
      nlines = $urandom_range(1, 3);
      total  = 0;
      for (int l = 0; l < nlines; l++) begin nchunks[l] = $urandom_range(1, 4); total += nchunks[l]; end
      exp_addr.delete(); exp_data.delete(); requested = 0; acked = 0;
      frame_base = base; line_stride = stride;
      pulse(P_GO);
      fork
        begin
          for (int l = 0; l < nlines; l++) begin
            bit combo;
            int guard;
            combo = (l > 0) && ($urandom_range(0, 1) == 1);
            if (l > 0) begin
              guard = 0;
              while (acked != requested && guard < 3000) begin @(negedge clock); guard++; end
              if (!combo) pulse(P_LINE);
            end
            for (int c = 0; c < nchunks[l]; c++) begin
              guard = 0;
              while (requested - acked >= 3 && guard < 3000) begin @(negedge clock); guard++; end
              exp_addr.push_back(base + 32'(l) * 32'(stride) + 32'(c * CHUNK * 4));
              requested++;
              pulse((combo && c == 0) ? P_BOTH : P_CHUNK);
              cyc($urandom_range(0, 3));
            end
          end
        end
        begin
          for (int b = 0; b < total; b++) begin
            bit ok;
            logic [31:0] want, d;
            wait_req(3000, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL rnd_req_timeout burst %0d got none want request", b); break; end
            want = (exp_addr.size() != 0) ? exp_addr.pop_front() : 32'hDEAD_BEEF;
            if (mem_addr !== want || mem_len !== 7'd16) begin
              fails++; $display("FAIL rnd_addr burst %0d got %h len %0d want %h len 16", b, mem_addr, mem_len, want);
            end
            cyc($urandom_range(0, 2));
            mem_ack = 1; @(negedge clock); mem_ack = 0;
            acked++;
            for (int i = 0; i < CHUNK; i++) begin
              cyc($urandom_range(0, 2));
              d = $urandom;
              mem_rvalid = 1; mem_rdata = d; exp_data.push_back(d);
              @(negedge clock);
              mem_rvalid = 0;
            end
          end
        end
        begin
          int popped, guard;
          popped = 0; guard = 0;
          while (popped < total * CHUNK && guard < 20000) begin
            read_fifo = 0;
            if (!fifo_empty && $urandom_range(0, 2) != 0) begin
              tests++;
              if (exp_data.size() == 0 || fifo_dout !== exp_data[0]) begin
                fails++; $display("FAIL rnd_data word %0d got %h want %h", popped, fifo_dout,
                                  (exp_data.size() != 0) ? exp_data[0] : 32'hx);
              end
              if (exp_data.size() != 0) void'(exp_data.pop_front());
              read_fifo = 1; popped++;
            end
            @(negedge clock); guard++;
          end
          read_fifo = 0;
          tests++;
          if (popped != total * CHUNK) begin fails++; $display("FAIL rnd_pop_timeout got %0d want %0d", popped, total * CHUNK); end
        end
      join
      tests++;
      if (fifo_empty !== 1'b1 || exp_data.size() != 0) begin
        fails++; $display("FAIL rnd_end got empty=%b left=%0d want 1 0", fifo_empty, exp_data.size());
      end
      pulse(P_DONE);
    end
  endtask

  initial begin
    test_reset();
`ifdef HDMI_FETCH_UNDERFLOW_EN
    test_underflow();
`endif
    test_basic_burst();
    test_line_advance();
    test_back_pressure();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
